// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS controller.
// master = control unit, slave = datapath/memory side.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       link;
  logic [1:0] reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       illegal;
  logic       bus_err;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           link, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal,
           bus_err, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           link, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal,
           bus_err, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM with memory-wait timeout and sticky traps.
// Optional feature: define MIPS_CTRL_BNE_EN to decode bne (opcode 000101).
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input logic                         clk,
  input logic                         rst,
  mips_multicycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    WB_MEM   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    EXEC_I   = 4'd8,
    WB_ALU   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    TRAP     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             wait_st_s;
  logic             timeout_s;

  // State, timeout counter and sticky trap flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    cnt_d         = '0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.ir_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.link       = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = ALU_ADD;

    wait_st_s = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    // mem_ready takes priority over an expiring count
    timeout_s = (MEM_TIMEOUT != 0) && wait_st_s && !bus.mem_ready &&
                (cnt_q == CNT_W'(MEM_TIMEOUT));

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:                  state_d = EXEC_R;
          OP_LW, OP_SW:              state_d = MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = EXEC_I;
          OP_BEQ:                    state_d = BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:                    state_d = BRANCH;
`endif
          OP_J:                      state_d = JUMP;
          OP_JAL:                    state_d = JAL;
          default: begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        if (bus.opcode == OP_SW) begin
          state_d = MEM_WR;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = WB_MEM;
        end else begin
          state_d = MEM_RD;
        end
      end
      WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = FETCH;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          state_d = FETCH;
        end else begin
          state_d = MEM_WR;
        end
      end
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        state_d       = WB_ALU;
      end
      EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        case (bus.opcode)
          OP_ANDI: bus.alu_op = ALU_AND;
          OP_ORI:  bus.alu_op = ALU_OR;
          default: bus.alu_op = ALU_ADD;
        endcase
        state_d = WB_ALU;
      end
      WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (bus.opcode == OP_RTYPE) ? 2'b01 : 2'b00;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = 2'b01;
`ifdef MIPS_CTRL_BNE_EN
        bus.pc_write  = (bus.opcode == OP_BNE) ? !bus.zero : bus.zero;
`else
        bus.pc_write  = bus.zero;
`endif
        state_d       = FETCH;
      end
      JUMP: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
        state_d      = FETCH;
      end
      JAL: begin
        bus.pc_src    = 2'b10;
        bus.pc_write  = 1'b1;
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'b10;
        bus.link      = 1'b1;
        state_d       = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase

    if (timeout_s) begin
      state_d   = TRAP;
      bus_err_d = 1'b1;
    end else begin
      bus_err_d = bus_err_d;
    end

    // Count only consecutive stalled cycles within one wait state
    if (wait_st_s && !bus.mem_ready && (state_d == state_q) && (MEM_TIMEOUT != 0)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control (MEM_TIMEOUT=3).
module tb_mips_multicycle_control;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mips_multicycle_control_if bus ();

  mips_multicycle_control #(.MEM_TIMEOUT(3), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pc_write pc_src ir_write i_or_d mem_read mem_write mem_to_reg link reg_dst reg_write alu_src_a alu_src_b alu_op
  function automatic logic [17:0] pk(input logic pcw, input logic [1:0] pcs, input logic irw,
                                     input logic iod, input logic mr, input logic mw,
                                     input logic m2r, input logic lnk, input logic [1:0] rd,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [2:0] aop);
    return {pcw, pcs, irw, iod, mr, mw, m2r, lnk, rd, rw, asa, asb, aop};
  endfunction

  logic [17:0] obs_ctl;
  assign obs_ctl = {bus.pc_write, bus.pc_src, bus.ir_write, bus.i_or_d, bus.mem_read,
                    bus.mem_write, bus.mem_to_reg, bus.link, bus.reg_dst, bus.reg_write,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op};

  logic [17:0] c_zero, c_f1, c_f0, c_dec, c_maddr, c_mrd, c_wbm, c_mwr;
  logic [17:0] c_exr, c_exi_or, c_wba_r, c_wba_i, c_br1, c_br0, c_jmp, c_jal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle at the falling edge, then advances one clock.
  task automatic step(input string tag, input logic [3:0] st, input logic [17:0] ctl,
                      input logic [1:0] flags);
    @(negedge clk);
    chk({tag, ".state"}, {28'd0, bus.state}, {28'd0, st});
    chk({tag, ".ctl"}, {14'd0, obs_ctl}, {14'd0, ctl});
    chk({tag, ".flags"}, {30'd0, bus.illegal, bus.bus_err}, {30'd0, flags});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    c_zero   = 18'd0;
    c_f1     = pk(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 3'b000);
    c_f0     = pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 3'b000);
    c_dec    = pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 3'b000);
    c_maddr  = pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 3'b000);
    c_mrd    = pk(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000);
    c_wbm    = pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000);
    c_mwr    = pk(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000);
    c_exr    = pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 3'b010);
    c_exi_or = pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 3'b100);
    c_wba_r  = pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 3'b000);
    c_wba_i  = pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000);
    c_br1    = pk(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 3'b001);
    c_br0    = pk(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 3'b001);
    c_jmp    = pk(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000);
    c_jal    = pk(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000);

    rst           = 1'b1;
    bus.opcode    = 6'b100011;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step("reset_idle", 4'd0, c_zero, 2'b00);

    // lw with two stall cycles in MEM_RD
    bus.mem_ready = 1'b1;
    step("lw_fetch", 4'd1, c_f1, 2'b00);
    step("lw_decode", 4'd2, c_dec, 2'b00);
    step("lw_maddr", 4'd3, c_maddr, 2'b00);
    bus.mem_ready = 1'b0;
    step("lw_mrd_w1", 4'd4, c_mrd, 2'b00);
    step("lw_mrd_w2", 4'd4, c_mrd, 2'b00);
    bus.mem_ready = 1'b1;
    step("lw_mrd_ok", 4'd4, c_mrd, 2'b00);
    step("lw_wb", 4'd5, c_wbm, 2'b00);

    // beq taken / not taken
    bus.opcode = 6'b000100;
    bus.zero   = 1'b1;
    step("beq1_fetch", 4'd1, c_f1, 2'b00);
    step("beq1_decode", 4'd2, c_dec, 2'b00);
    step("beq1_branch", 4'd10, c_br1, 2'b00);
    bus.zero = 1'b0;
    step("beq0_fetch", 4'd1, c_f1, 2'b00);
    step("beq0_decode", 4'd2, c_dec, 2'b00);
    step("beq0_branch", 4'd10, c_br0, 2'b00);

    // jal
    bus.opcode = 6'b000011;
    step("jal_fetch", 4'd1, c_f1, 2'b00);
    step("jal_decode", 4'd2, c_dec, 2'b00);
    step("jal_exec", 4'd12, c_jal, 2'b00);

    // j
    bus.opcode = 6'b000010;
    step("j_fetch", 4'd1, c_f1, 2'b00);
    step("j_decode", 4'd2, c_dec, 2'b00);
    step("j_exec", 4'd11, c_jmp, 2'b00);

    // R-type
    bus.opcode = 6'b000000;
    step("r_fetch", 4'd1, c_f1, 2'b00);
    step("r_decode", 4'd2, c_dec, 2'b00);
    step("r_exec", 4'd7, c_exr, 2'b00);
    step("r_wb", 4'd9, c_wba_r, 2'b00);

    // ori
    bus.opcode = 6'b001101;
    step("ori_fetch", 4'd1, c_f1, 2'b00);
    step("ori_decode", 4'd2, c_dec, 2'b00);
    step("ori_exec", 4'd8, c_exi_or, 2'b00);
    step("ori_wb", 4'd9, c_wba_i, 2'b00);

    // sw with one stall in MEM_WR
    bus.opcode = 6'b101011;
    step("sw_fetch", 4'd1, c_f1, 2'b00);
    step("sw_decode", 4'd2, c_dec, 2'b00);
    step("sw_maddr", 4'd3, c_maddr, 2'b00);
    bus.mem_ready = 1'b0;
    step("sw_mwr_w1", 4'd6, c_mwr, 2'b00);
    bus.mem_ready = 1'b1;
    step("sw_mwr_ok", 4'd6, c_mwr, 2'b00);

    // bne: branch when enabled, trap otherwise
    bus.opcode = 6'b000101;
    bus.zero   = 1'b0;
    step("bne_fetch", 4'd1, c_f1, 2'b00);
    step("bne_decode", 4'd2, c_dec, 2'b00);
`ifdef MIPS_CTRL_BNE_EN
    step("bne_branch", 4'd10, c_br1, 2'b00);
    step("bne_next", 4'd1, c_f1, 2'b00);
`else
    step("bne_trap", 4'd13, c_zero, 2'b10);
`endif

    // mid-instruction reset aborts a pending lw read
    do_reset();
    step("rst2_idle", 4'd0, c_zero, 2'b00);
    bus.opcode = 6'b100011;
    step("ab_fetch", 4'd1, c_f1, 2'b00);
    step("ab_decode", 4'd2, c_dec, 2'b00);
    step("ab_maddr", 4'd3, c_maddr, 2'b00);
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    step("ab_mrd", 4'd4, c_mrd, 2'b00);
    rst = 1'b0;
    step("ab_idle", 4'd0, c_zero, 2'b00);

    // illegal opcode traps and holds
    bus.opcode    = 6'b111111;
    bus.mem_ready = 1'b1;
    step("ill_fetch", 4'd1, c_f1, 2'b00);
    step("ill_decode", 4'd2, c_dec, 2'b00);
    for (int i = 0; i < 20; i++) begin
      step("ill_trap", 4'd13, c_zero, 2'b10);
    end
    do_reset();
    step("rst3_idle", 4'd0, c_zero, 2'b00);

    // bus timeout after the 4th stalled FETCH cycle
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("to_fetch", 4'd1, c_f0, 2'b00);
    end
    step("to_trap", 4'd13, c_zero, 2'b01);
    step("to_hold", 4'd13, c_zero, 2'b01);
    do_reset();
    step("rst4_idle", 4'd0, c_zero, 2'b00);

    // ready on the 4th cycle beats the timeout
    for (int i = 0; i < 3; i++) begin
      step("nto_fetch", 4'd1, c_f0, 2'b00);
    end
    bus.mem_ready = 1'b1;
    step("nto_fetch4", 4'd1, c_f1, 2'b00);
    step("nto_decode", 4'd2, c_dec, 2'b00);
    step("nto_exec", 4'd7, c_exr, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
